stage_id_pipe: RTL
==================

# stage_id_pipe

Registered, parametrised RV32I decode stage with a valid/ready handshake on both sides. It sits between the IF/ID latch and the EX stage. It decodes the instruction, reads the register file, and forwards operands from NFWD younger producers. It interlocks on load-use hazards and can flush on redirect. Its output is a pipeline register, so the ID→EX boundary needs no separate latch.

## Interface
- XLEN, 32: datapath width; immediates sign-extend to XLEN.
- NFWD, 2: number of forwarding sources; index 0 is youngest and has highest priority.
- CNTW, 16: width of the stall performance counter.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1  upstream handshake
- in_pc  in  XLEN  instruction PC
- in_inst  in  32  instruction word
- in_predict  in  1  IF predicted taken
- flush  in  1  discard held and incoming instruction
- rf_raddr1, rf_raddr2  out  5  register-file read addresses (combinational from in_inst)
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data, same cycle
- fwd_write  in  NFWD  source i will write fwd_addr[i]
- fwd_pending  in  NFWD  source i's value is not ready yet (load in EX)
- fwd_addr  in  NFWD*5  destination register per source
- fwd_data  in  NFWD*XLEN  value per source
- out_valid / out_ready  out / in  1  downstream handshake
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  operands
- out_rd_addr  out  5  destination register
- out_rd_write, out_rd_load  out  1  destination writes back; destination is a load
- out_op  out  4  operation code (package enum)
- out_category  out  3  operation category (package enum)
- out_sel_pc, out_sel_imm  out  1  operand1 = pc; operand2 = imm
- out_branch, out_jump, out_predict, out_illegal  out  1  control flags
- stall_o  out  1  load-use interlock active this cycle
- perf_stall_cnt  out  CNTW  saturating count of interlock cycles
- redirect_valid  out  1  early-branch redirect (macro only)
- redirect_pc  out  XLEN  redirect target (macro only)

## Operation
- Register-read request per format:
  - LUI, AUIPC, JAL: no reads.
  - JALR, LOAD, OP-IMM: rs1 only.
  - BRANCH, STORE, OP: rs1 and rs2.
  - Reads of x0 return 0 and never hazard.
- Operand select for each requested rs: the lowest i with fwd_write[i] and fwd_addr[i]==rs. If that source has fwd_pending[i], raise a hazard; otherwise take fwd_data[i]. With no match, take rf_rdata.
- stall_o = hazard & in_valid.
- in_ready = !stall_o & (!out_valid | out_ready).
- Accept = in_valid & in_ready & !flush. On accept, the output register loads the decoded fields.
- Otherwise, if out_ready is high, out_valid clears, which inserts a bubble during a stall.
- Two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1. Moves to EMPTY on out_ready without accept; stays FULL on accept.
- flush has priority over everything. It forces out_valid=0 next cycle, drops the incoming instruction, and does not count as a stall.
- Unknown opcode or funct: out_illegal=1, out_rd_write=0, category Arith / op Add. The instruction still flows.
- shift-imm uses shamt as the immediate. OP funct7[5] selects sub/sra. OP-IMM funct7[5] selects sra.
- JAL/JALR: out_sel_pc=1, out_imm=4 for the link add. The target offset goes in out_rs2_data. JALR forwards rs1 normally.
- perf_stall_cnt increments on every stall_o cycle and saturates at all-ones.

## Timing
- Reset values: out_valid=0, all out_* = 0, redirect_valid=0, perf_stall_cnt=0. in_ready=1 from the first cycle after reset, unless stall_o is asserted.
- Latency is 1 cycle from accept to out_valid. Full throughput is one instruction per cycle.
- Outputs hold stable while out_valid & !out_ready.
- Hazard and out_ready low in the same cycle: the register holds and the counter still increments.
- Reset asserted mid-stall clears the counter and the state in the same edge.

## Configuration
- STAGE_ID_EARLY_BRANCH_EN defined:
  - On accept of a BRANCH, ID evaluates the condition on the forwarded operands.
  - If the outcome ≠ in_predict, redirect_valid pulses one cycle, aligned with out_valid.
  - redirect_pc is in_pc+imm when taken, in_pc+4 when not.
  - out_branch=0 for resolved branches.
  - A flush in the pulse cycle does not cancel the pulse.
- Undefined: redirect_valid and redirect_pc are tied to 0, and branches go to EX with out_branch=1.

## Structure
- riscv_pkg holds:
  - opcode constants
  - the Op and Category enums
  - the XLEN default
- Sub-module id_decoder is purely combinational. It maps in_inst to imm, the control fields, and the read requests. The top level handles the register, forwarding and hazard logic.

## Test plan
- Reset: assert rst 2 cycles → out_valid=0, in_ready=1, perf_stall_cnt=0.
- Accept 0x00500093 (addi x1,x0,5) at pc 0x100 → next cycle out_valid=1, out_imm=5, out_rd_addr=1, out_rd_write=1, out_sel_imm=1.
- Forwarding priority:
  - Stimulus: fwd0 x1=0x11, fwd1 x1=0x22, rf=0x33; add x2,x1,x1.
  - Response: out_rs1_data=out_rs2_data=0x11.
- Load-use interlock:
  - Stimulus: fwd_pending[0]=1 on x1 for 2 cycles with out_ready=1.
  - Response: stall_o=1, in_ready=0, bubble emitted, perf_stall_cnt=2; accepted on the third cycle.
- Back-pressure and flush:
  - out_ready=0 for 3 cycles → outputs unchanged.
  - flush with in_valid=1 → out_valid=0 next cycle, instruction lost.
- With STAGE_ID_EARLY_BRANCH_EN: beq x0,x0,+8 at 0x200 with in_predict=0 → redirect_valid pulse, redirect_pc=0x208, out_branch=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, decode enums and control bundle shared by the ID stage.
package riscv_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
    } op_e;
    typedef enum logic [2:0] {CAT_ARITH, CAT_LOAD, CAT_STORE, CAT_BRANCH, CAT_JUMP} cat_e;
    typedef struct packed {
        op_e        op;
        cat_e       cat;
        logic [4:0] rd;
        logic       rd_write;
        logic       rd_load;
        logic       sel_pc;
        logic       sel_imm;
        logic       branch;
        logic       jump;
        logic       illegal;
        logic       rs1_req;
        logic       rs2_req;
    } ctrl_t;
    function automatic op_e alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? OP_SUB : OP_ADD;
            3'd1: return OP_SLL;
            3'd2: return OP_SLT;
            3'd3: return OP_SLTU;
            3'd4: return OP_XOR;
            3'd5: return alt ? OP_SRA : OP_SRL;
            3'd6: return OP_OR;
            default: return OP_AND;
        endcase
    endfunction
    function automatic op_e br_op(input logic [2:0] f3);
        case (f3)
            3'd0: return OP_BEQ;
            3'd1: return OP_BNE;
            3'd4: return OP_BLT;
            3'd5: return OP_BGE;
            3'd6: return OP_BLTU;
            default: return OP_BGEU;
        endcase
    endfunction
endpackage

// File: rtl/stage_id_pipe_if.sv
// stage_id_pipe_if: IF/ID input and ID/EX output handshake buses of the decode stage.
interface stage_id_pipe_if import riscv_pkg::*; #(parameter int XLEN = XLEN_DEF) ();
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            in_predict;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd_addr;
    logic            out_rd_write;
    logic            out_rd_load;
    op_e             out_op;
    cat_e            out_category;
    logic            out_sel_pc;
    logic            out_sel_imm;
    logic            out_branch;
    logic            out_jump;
    logic            out_predict;
    logic            out_illegal;
    modport master (
        output in_valid, in_pc, in_inst, in_predict, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd_addr,
               out_rd_write, out_rd_load, out_op, out_category, out_sel_pc, out_sel_imm,
               out_branch, out_jump, out_predict, out_illegal
    );
    modport slave (
        input  in_valid, in_pc, in_inst, in_predict, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd_addr,
               out_rd_write, out_rd_load, out_op, out_category, out_sel_pc, out_sel_imm,
               out_branch, out_jump, out_predict, out_illegal
    );
endinterface

// File: rtl/stage_id_pipe_id_decoder.sv
// id_decoder: combinational RV32I decode of an instruction word into immediate, jump target and controls.
module id_decoder import riscv_pkg::*; #(parameter int XLEN = XLEN_DEF) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] tgt,
    output ctrl_t           ctrl
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    logic ill;
    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign shamt = XLEN'(inst[24:20]);
    // jumps put the link increment in imm and carry the real offset in tgt
    always_comb begin
        ctrl = '0;
        imm  = '0;
        tgt  = '0;
        ill  = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                ctrl.rd_write = 1'b1;
                ctrl.sel_imm  = 1'b1;
                ctrl.sel_pc   = opc == OPC_AUIPC;
                imm           = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                ctrl.cat      = CAT_JUMP;
                ctrl.jump     = 1'b1;
                ctrl.rd_write = 1'b1;
                ctrl.sel_pc   = 1'b1;
                ctrl.sel_imm  = 1'b1;
                ctrl.rs1_req  = opc == OPC_JALR;
                imm           = XLEN'(4);
                tgt           = opc == OPC_JALR ? imm_i : imm_j;
                ill           = opc == OPC_JALR && f3 != 3'd0;
            end
            OPC_BRANCH: begin
                ctrl.cat     = CAT_BRANCH;
                ctrl.op      = br_op(f3);
                ctrl.branch  = 1'b1;
                ctrl.rs1_req = 1'b1;
                ctrl.rs2_req = 1'b1;
                imm          = imm_b;
                ill          = f3[2:1] == 2'b01;
            end
            OPC_LOAD: begin
                ctrl.cat      = CAT_LOAD;
                ctrl.rd_write = 1'b1;
                ctrl.rd_load  = 1'b1;
                ctrl.sel_imm  = 1'b1;
                ctrl.rs1_req  = 1'b1;
                imm           = imm_i;
                ill           = f3 == 3'd3 || f3 >= 3'd6;
            end
            OPC_STORE: begin
                ctrl.cat     = CAT_STORE;
                ctrl.sel_imm = 1'b1;
                ctrl.rs1_req = 1'b1;
                ctrl.rs2_req = 1'b1;
                imm          = imm_s;
                ill          = f3 > 3'd2;
            end
            OPC_OPIMM: begin
                ctrl.op       = alu_op(f3, f3 == 3'd5 && f7[5]);
                ctrl.rd_write = 1'b1;
                ctrl.sel_imm  = 1'b1;
                ctrl.rs1_req  = 1'b1;
                imm           = (f3 == 3'd1 || f3 == 3'd5) ? shamt : imm_i;
                ill           = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && (f7 & 7'h5f) != 7'd0);
            end
            OPC_OP: begin
                ctrl.op       = alu_op(f3, f7[5]);
                ctrl.rd_write = 1'b1;
                ctrl.rs1_req  = 1'b1;
                ctrl.rs2_req  = 1'b1;
                ill           = (f7 & 7'h5f) != 7'd0 || (f7[5] && f3 != 3'd0 && f3 != 3'd5);
            end
            default: ill = 1'b1;
        endcase
        ctrl.rd = ctrl.rd_write ? inst[11:7] : 5'd0;
        if (ill) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            imm          = '0;
            tgt          = '0;
        end
    end
endmodule

// File: rtl/stage_id_pipe.sv
// stage_id_pipe: registered RV32I decode stage with operand forwarding, load-use interlock and flush.
// STAGE_ID_EARLY_BRANCH_EN resolves branches in ID and pulses redirect_valid on a misprediction.
module stage_id_pipe import riscv_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int NFWD = 2,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    stage_id_pipe_if.slave     bus,
    input  logic               flush,
    output logic [4:0]         rf_raddr1,
    output logic [4:0]         rf_raddr2,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic [XLEN-1:0]    rf_rdata2,
    input  logic [NFWD-1:0]    fwd_write,
    input  logic [NFWD-1:0]    fwd_pending,
    input  logic [NFWD*5-1:0]  fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic               stall_o,
    output logic [CNTW-1:0]    perf_stall_cnt,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);
    typedef enum logic {EMPTY, FULL} state_e;
    state_e state, state_n;
    ctrl_t c;
    logic [XLEN-1:0] imm, tgt, op1, op2;
    logic pend1, pend2, accept;
    id_decoder #(.XLEN(XLEN)) u_dec (.inst(bus.in_inst), .imm(imm), .tgt(tgt), .ctrl(c));
    assign rf_raddr1 = bus.in_inst[19:15];
    assign rf_raddr2 = bus.in_inst[24:20];
    // walk oldest to youngest so the lowest matching index wins
    always_comb begin
        op1   = rf_rdata1;
        op2   = rf_rdata2;
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_write[i] && fwd_addr[i*5+:5] == rf_raddr1) begin
                op1   = fwd_data[i*XLEN+:XLEN];
                pend1 = fwd_pending[i];
            end
            if (fwd_write[i] && fwd_addr[i*5+:5] == rf_raddr2) begin
                op2   = fwd_data[i*XLEN+:XLEN];
                pend2 = fwd_pending[i];
            end
        end
        if (!c.rs1_req || rf_raddr1 == 5'd0) begin
            op1   = '0;
            pend1 = 1'b0;
        end
        if (!c.rs2_req || rf_raddr2 == 5'd0) begin
            op2   = '0;
            pend2 = 1'b0;
        end
    end
    assign stall_o      = (pend1 | pend2) & bus.in_valid & !flush;
    assign bus.in_ready = !stall_o & (!bus.out_valid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready & !flush;
    always_ff @(posedge clk) state <= rst ? EMPTY : state_n;
    always_comb state_n = flush ? EMPTY : accept ? FULL : bus.out_ready ? EMPTY : state;
    always_comb bus.out_valid = state == FULL;
    always_ff @(posedge clk)
        if (rst) begin
            bus.out_pc       <= '0;
            bus.out_rs1_data <= '0;
            bus.out_rs2_data <= '0;
            bus.out_imm      <= '0;
            bus.out_rd_addr  <= '0;
            bus.out_rd_write <= 1'b0;
            bus.out_rd_load  <= 1'b0;
            bus.out_op       <= OP_ADD;
            bus.out_category <= CAT_ARITH;
            bus.out_sel_pc   <= 1'b0;
            bus.out_sel_imm  <= 1'b0;
            bus.out_branch   <= 1'b0;
            bus.out_jump     <= 1'b0;
            bus.out_predict  <= 1'b0;
            bus.out_illegal  <= 1'b0;
        end else if (accept) begin
            bus.out_pc       <= bus.in_pc;
            bus.out_rs1_data <= op1;
            bus.out_rs2_data <= c.jump ? tgt : op2;
            bus.out_imm      <= imm;
            bus.out_rd_addr  <= c.rd;
            bus.out_rd_write <= c.rd_write;
            bus.out_rd_load  <= c.rd_load;
            bus.out_op       <= c.op;
            bus.out_category <= c.cat;
            bus.out_sel_pc   <= c.sel_pc;
            bus.out_sel_imm  <= c.sel_imm;
`ifdef STAGE_ID_EARLY_BRANCH_EN
            bus.out_branch   <= 1'b0;
`else
            bus.out_branch   <= c.branch;
`endif
            bus.out_jump     <= c.jump;
            bus.out_predict  <= bus.in_predict;
            bus.out_illegal  <= c.illegal;
        end
    always_ff @(posedge clk)
        if (rst) perf_stall_cnt <= '0;
        else if (stall_o && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + CNTW'(1);
`ifdef STAGE_ID_EARLY_BRANCH_EN
    logic taken;
    always_comb
        case (c.op)
            OP_BEQ:  taken = op1 == op2;
            OP_BNE:  taken = op1 != op2;
            OP_BLT:  taken = $signed(op1) < $signed(op2);
            OP_BGE:  taken = $signed(op1) >= $signed(op2);
            OP_BLTU: taken = op1 < op2;
            OP_BGEU: taken = op1 >= op2;
            default: taken = 1'b0;
        endcase
    // registered so the pulse lines up with out_valid and survives a flush in that cycle
    always_ff @(posedge clk)
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & c.branch & (taken != bus.in_predict);
            if (accept && c.branch) redirect_pc <= taken ? bus.in_pc + imm : bus.in_pc + XLEN'(4);
        end
`else
    assign redirect_valid = 1'b0;
    assign redirect_pc    = '0;
`endif
endmodule
